// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a PC, fetches words over a req/ack handshake and strobes them into the IR.
// Optional halt-opcode detection is enabled by defining IF_HALT_DETECT_EN.
module instr_fetch #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'h3F
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              next_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ir_data_o,
    output logic              ir_w_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              halted_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_REDIR
`ifdef IF_HALT_DETECT_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fetchPc_q;
    logic              redir_q;
    logic              memReq_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] irData_q;
    logic              irW_q;
    logic [ADDR_W-1:0] pc_q;
    logic              busy_q;
    logic              halted_q;

    logic [ADDR_W-1:0] nextPc_d;
    logic              isHalt;

    assign nextPc_d = memAddr_q + ADDR_W'(1);

`ifdef IF_HALT_DETECT_EN
    assign isHalt = (mem_rdata_i[DATA_W-1 -: 6] == HALT_OP);
`else
    logic unusedHaltOp;
    assign unusedHaltOp = ^HALT_OP;
    assign isHalt       = 1'b0;
`endif

    // fetchPc_q doubles as the latched redirect target while redir_q is set
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            fetchPc_q <= RESET_PC;
            redir_q   <= 1'b0;
            memReq_q  <= 1'b0;
            memAddr_q <= RESET_PC;
            irData_q  <= '0;
            irW_q     <= 1'b0;
            pc_q      <= RESET_PC;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            irW_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        memReq_q  <= 1'b1;
                        memAddr_q <= fetchPc_q;
                        busy_q    <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        memReq_q <= 1'b0;
                        if (redir_q || branch_i) begin
                            redir_q <= 1'b0;
                            if (branch_i) begin
                                fetchPc_q <= branch_addr_i;
                            end
                            state_q <= S_REDIR;
                        end else begin
                            irData_q  <= mem_rdata_i;
                            pc_q      <= memAddr_q;
                            fetchPc_q <= nextPc_d;
                            irW_q     <= 1'b1;
                            if (isHalt) begin
`ifdef IF_HALT_DETECT_EN
                                halted_q <= 1'b1;
                                busy_q   <= 1'b0;
                                state_q  <= S_HALT;
`else
                                state_q  <= S_WAIT;
`endif
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end
                    end else if (branch_i) begin
                        redir_q   <= 1'b1;
                        fetchPc_q <= branch_addr_i;
                    end
                end
                S_WAIT: begin
                    if (branch_i) begin
                        fetchPc_q <= branch_addr_i;
                        memReq_q  <= 1'b1;
                        memAddr_q <= branch_addr_i;
                        state_q   <= S_REQ;
                    end else if (next_i) begin
                        memReq_q  <= 1'b1;
                        memAddr_q <= fetchPc_q;
                        state_q   <= S_REQ;
                    end
                end
                // Single idle cycle between a discarded word and the redirected request
                S_REDIR: begin
                    memReq_q <= 1'b1;
                    if (branch_i) begin
                        fetchPc_q <= branch_addr_i;
                        memAddr_q <= branch_addr_i;
                    end else begin
                        memAddr_q <= fetchPc_q;
                    end
                    state_q <= S_REQ;
                end
`ifdef IF_HALT_DETECT_EN
                S_HALT: begin
                    state_q <= S_HALT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o  = memReq_q;
    assign mem_addr_o = memAddr_q;
    assign ir_data_o  = irData_q;
    assign ir_w_o     = irW_q;
    assign pc_o       = pc_q;
    assign busy_o     = busy_q;
    assign halted_o   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural memory answers requests and two
// scoreboards hold the expected request addresses and the expected IR writes.
module tb_instr_fetch;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        next;
    logic        branch;
    logic [9:0]  branchAddr;
    logic        memReq;
    logic [9:0]  memAddr;
    logic        memAck;
    logic [15:0] memRdata;
    logic [15:0] irData;
    logic        irW;
    logic [9:0]  pc;
    logic        busy;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int stallCycles = 0;
    int waitCnt  = 0;

    logic [15:0] mem [0:1023];
    logic [9:0]  addrQ [$];
    logic [25:0] irQ [$];
    logic        prevReq = 1'b0;
    logic [9:0]  expAddr;
    logic [25:0] expIr;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .start_i       (start),
        .next_i        (next),
        .branch_i      (branch),
        .branch_addr_i (branchAddr),
        .mem_req_o     (memReq),
        .mem_addr_o    (memAddr),
        .mem_ack_i     (memAck),
        .mem_rdata_i   (memRdata),
        .ir_data_o     (irData),
        .ir_w_o        (irW),
        .pc_o          (pc),
        .busy_o        (busy),
        .halted_o      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after stallCycles low-phase samples of a held request
    always @(negedge clk) begin
        memAck = 1'b0;
        if (!rstN || !memReq) begin
            waitCnt = 0;
        end else if (waitCnt >= stallCycles) begin
            memAck   = 1'b1;
            memRdata = mem[memAddr];
            waitCnt  = 0;
        end else begin
            waitCnt++;
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            if (memReq && !prevReq) begin
                checks++;
                if (addrQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL req_addr unexpected request mem_addr=%h", memAddr);
                end else begin
                    expAddr = addrQ.pop_front();
                    if (memAddr !== expAddr) begin
                        failures++;
                        $display("[TB] FAIL req_addr got=%h expected=%h", memAddr, expAddr);
                    end
                end
            end
            if (irW === 1'b1) begin
                checks++;
                if (irQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL ir_write unexpected ir_w data=%h pc=%h", irData, pc);
                end else begin
                    expIr = irQ.pop_front();
                    if (irData !== expIr[25:10] || pc !== expIr[9:0]) begin
                        failures++;
                        $display("[TB] FAIL ir_write got data=%h pc=%h expected data=%h pc=%h",
                                 irData, pc, expIr[25:10], expIr[9:0]);
                    end
                end
            end
        end
        prevReq = memReq;
    end

    task automatic waitIrW(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (irW === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulseNext();
        next = 1'b1;
        @(posedge clk);
        #1 next = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (memReq !== 1'b0 || irW !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got req=%b irw=%b busy=%b halted=%b expected 0000",
                     memReq, irW, busy, halted);
        end
        checks++;
        if (pc !== 10'h0 || memAddr !== 10'h0 || irData !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got pc=%h addr=%h data=%h expected 0", pc, memAddr, irData);
        end
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_no_start got req=%b busy=%b expected 0 0", memReq, busy);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        mem[0] = 16'h0401;
        mem[1] = 16'h0802;
        stallCycles = 1;
        addrQ.push_back(10'h000);
        irQ.push_back({16'h0401, 10'h000});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_latency got req=%b busy=%b expected 1 1", memReq, busy);
        end
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL seq_word0 got no ir_w expected ir_w within bound");
        end
        addrQ.push_back(10'h001);
        irQ.push_back({16'h0802, 10'h001});
        pulseNext();
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL seq_word1 got no ir_w expected ir_w within bound");
        end
        @(negedge clk);
        checks++;
        if (irW !== 1'b0 || irData !== 16'h0802 || pc !== 10'h001 || memReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wait_hold got irw=%b data=%h pc=%h req=%b expected 0 0802 001 0",
                     irW, irData, pc, memReq);
        end
    endtask

    task automatic test_branch_wait();
        bit ok;
        stallCycles = 0;
        mem[10'h155] = 16'h1234;
        addrQ.push_back(10'h155);
        irQ.push_back({16'h1234, 10'h155});
        branch = 1'b1;
        branchAddr = 10'h155;
        next = 1'b1;
        @(posedge clk);
        #1 begin branch = 1'b0; next = 1'b0; end
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL branch_wait got no ir_w expected word at 155");
        end
    endtask

    task automatic test_branch_req();
        bit ok;
        int lowCnt;
        int guard;
        stallCycles = 4;
        mem[10'h005] = 16'hDEAD;
        mem[10'h020] = 16'h2020;
        addrQ.push_back(10'h005);
        addrQ.push_back(10'h020);
        irQ.push_back({16'h2020, 10'h020});
        branch = 1'b1;
        branchAddr = 10'h005;
        @(posedge clk);
        #1 branch = 1'b0;
        @(posedge clk);
        #1 begin branch = 1'b1; branchAddr = 10'h020; end
        @(posedge clk);
        #1 branch = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (memReq && guard < 20);
        lowCnt = 0;
        guard = 0;
        while (!memReq && guard < 20) begin
            lowCnt++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (lowCnt != 1) begin
            failures++;
            $display("[TB] FAIL redirect_gap got low_cycles=%0d expected 1", lowCnt);
        end
        checks++;
        if (memAddr !== 10'h020) begin
            failures++;
            $display("[TB] FAIL redirect_addr got=%h expected=020", memAddr);
        end
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL redirect_word got no ir_w expected word at 020");
        end
    endtask

    task automatic test_wrap();
        bit ok;
        stallCycles = 0;
        mem[10'h3FF] = 16'h0BFF;
        addrQ.push_back(10'h3FF);
        irQ.push_back({16'h0BFF, 10'h3FF});
        branch = 1'b1;
        branchAddr = 10'h3FF;
        @(posedge clk);
        #1 branch = 1'b0;
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wrap_last got no ir_w expected word at 3FF");
        end
        addrQ.push_back(10'h000);
        irQ.push_back({16'h0401, 10'h000});
        pulseNext();
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wrap_zero got no ir_w expected word at 000");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] word;
        for (int k = 1; k <= 4; k++) begin
            stallCycles = $urandom_range(0, 3);
            word = {6'(k), 10'($urandom)};
            mem[k] = word;
            addrQ.push_back(10'(k));
            irQ.push_back({word, 10'(k)});
            pulseNext();
            waitIrW(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL b2b_word%0d got no ir_w expected word", k);
            end
        end
    endtask

    task automatic test_reset_mid();
        stallCycles = 4;
        addrQ.push_back(10'h005);
        pulseNext();
        @(negedge clk);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (memReq !== 1'b0 || irW !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_ctrl got req=%b irw=%b busy=%b halted=%b expected 0000",
                     memReq, irW, busy, halted);
        end
        checks++;
        if (pc !== 10'h0 || memAddr !== 10'h0 || irData !== 16'h0) begin
            failures++;
            $display("[TB] FAIL midreset_data got pc=%h addr=%h data=%h expected 0", pc, memAddr, irData);
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (memReq !== 1'b0 || busy !== 1'b0 || irQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL after_reset got req=%b busy=%b pending=%0d expected 0 0 0",
                     memReq, busy, irQ.size());
        end
    endtask

    task automatic test_halt();
        bit ok;
        bit reqSeen;
        logic expHalt;
`ifdef IF_HALT_DETECT_EN
        expHalt = 1'b1;
`else
        expHalt = 1'b0;
`endif
        stallCycles = 0;
        addrQ.push_back(10'h000);
        irQ.push_back({16'h0401, 10'h000});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitIrW(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL restart_word got no ir_w expected word at 000");
        end
        mem[10'h030] = 16'hFC00;
        addrQ.push_back(10'h030);
        irQ.push_back({16'hFC00, 10'h030});
        branch = 1'b1;
        branchAddr = 10'h030;
        @(posedge clk);
        #1 branch = 1'b0;
        waitIrW(ok);
        checks++;
        if (!ok || halted !== expHalt) begin
            failures++;
            $display("[TB] FAIL halt_word got irw_seen=%b halted=%b expected 1 %b", ok, halted, expHalt);
        end
`ifdef IF_HALT_DETECT_EN
        next = 1'b1;
        branch = 1'b1;
        branchAddr = 10'h040;
        @(posedge clk);
        #1 begin next = 1'b0; branch = 1'b0; end
        reqSeen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (memReq) reqSeen = 1'b1;
        end
        checks++;
        if (reqSeen || halted !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halt_stuck got req_seen=%b halted=%b busy=%b expected 0 1 0",
                     reqSeen, halted, busy);
        end
`else
        reqSeen = 1'b0;
        mem[10'h031] = 16'h0031;
        addrQ.push_back(10'h031);
        irQ.push_back({16'h0031, 10'h031});
        pulseNext();
        waitIrW(ok);
        checks++;
        if (!ok || halted !== 1'b0 || busy !== 1'b1 || reqSeen) begin
            failures++;
            $display("[TB] FAIL no_halt got irw_seen=%b halted=%b busy=%b expected 1 0 1", ok, halted, busy);
        end
`endif
    endtask

    initial begin
        rstN = 1'b0;
        start = 1'b0;
        next = 1'b0;
        branch = 1'b0;
        branchAddr = '0;
        memAck = 1'b0;
        memRdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        test_reset();
        test_sequential();
        test_branch_wait();
        test_branch_req();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        repeat (3) @(negedge clk);
        checks++;
        if (addrQ.size() != 0 || irQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got addr_pending=%0d ir_pending=%0d expected 0 0",
                     addrQ.size(), irQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
